// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: in-order imem reads, prefetch FIFO and the IF/ID decode register.
// Define IF_FETCH_MISALIGN_CHECK_EN to add the sticky misaligned-redirect flag misalign_o.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o
`ifdef IF_FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OutW-1:0] out_q, out_d;
  logic [OutW-1:0] drop_q, drop_d;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];

  logic        req;
  logic        grant;
  logic        push;
  logic        pop;
  logic        advance;
  logic        fifo_empty;
  logic [31:0] target;

`ifdef IF_FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign target     = {PCTargetE_i[31:2], 2'b00};
  assign misalign_d = misalign_q | (PCSrcE_i & (PCTargetE_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign target = PCTargetE_i;
`endif

  // Gating counts in-flight requests against free FIFO slots so a response always has room.
  assign req = rst_ni && !PCSrcE_i
             && (32'(out_q) < MAX_OUTSTANDING)
             && ((32'(cnt_q) + 32'(out_q)) < FIFO_DEPTH);

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  assign grant      = req && imem_gnt_i;
  assign fifo_empty = (cnt_q == '0);
  assign push       = imem_rvalid_i && (drop_q == '0) && !PCSrcE_i;
  assign advance    = !FlushD_i && !PCSrcE_i && !StallD_i;
  assign pop        = advance && !fifo_empty;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    out_d     = out_q + OutW'(grant) - OutW'(imem_rvalid_i);

    if (PCSrcE_i) begin
      // Everything already requested belongs to the old path, including a response landing now.
      pc_d      = target;
      resp_pc_d = target;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      drop_d    = out_q - OutW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rvalid_i && (drop_q != '0)) begin
        drop_d = drop_q - OutW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;

    if (FlushD_i || PCSrcE_i) begin
      valid_d = 1'b0;
      instr_d = Nop;
    end else if (StallD_i) begin
      valid_d = valid_q;
    end else if (!fifo_empty) begin
      valid_d = 1'b1;
      instr_d = fifo_instr_q[rptr_q];
      pcd_d   = fifo_pc_q[rptr_q];
      pcp4_d  = fifo_pc_q[rptr_q] + 32'd4;
    end else begin
      // Bubble: PCs keep their last value so only ValidD_o/InstrD_o mark the hole.
      valid_d = 1'b0;
      instr_d = Nop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      instr_q   <= Nop;
      pcd_q     <= '0;
      pcp4_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wptr_q] <= imem_rdata_i;
      fifo_pc_q[wptr_q]    <= resp_pc_q;
    end
  end

  assign InstrD_o   = instr_q;
  assign PCD_o      = pcd_q;
  assign PCPlus4D_o = pcp4_q;
  assign ValidD_o   = valid_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (32'(cnt_q) == FIFO_DEPTH)));

  a_out_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(out_q) <= MAX_OUTSTANDING);

  a_rvalid_has_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (out_q != '0));

  a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (imem_req_o && !imem_gnt_i) |=> (!imem_req_o || $stable(imem_addr_o)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a directed vector table, hand-written redirect/grant sequences and
// randomized traffic scored against a program-order model of fetch and decode.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] Key     = 32'hA5A5_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          MaxOut  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        pcsrc;
  logic [31:0] target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcp4_d;
  logic        valid_d;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC       (ResetPc),
    .FIFO_DEPTH     (4),
    .MAX_OUTSTANDING(MaxOut)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (imem_gnt),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .StallD_i     (stall),
    .FlushD_i     (flush),
    .PCSrcE_i     (pcsrc),
    .PCTargetE_i  (target),
    .InstrD_o     (instr_d),
    .PCD_o        (pc_d),
    .PCPlus4D_o   (pcp4_d),
    .ValidD_o     (valid_d)
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o   (misalign)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_pcd;
    logic        exp_req;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  pend_t       pend[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;
  logic [31:0] model_fpc;
  logic [31:0] exp_pc;
  logic        last_stalled;
  logic [31:0] last_addr;
  logic        pv;
  logic [31:0] pi, pp, pp4;

  function automatic logic [31:0] tgt_of(input logic [31:0] t);
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: memory response, grant decision and fetch-side checks, then the edge.
  task automatic step();
    logic r;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr ^ Key;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    r = imem_req;
    if (!rst_n) check("req_in_reset", 32'(r), 32'd0);
    if (pcsrc)  check("req_in_redirect", 32'(r), 32'd0);
    if (r && last_stalled) check("addr_stable", imem_addr, last_addr);
    if (r) check("fetch_addr", imem_addr, model_fpc);
    last_stalled = r && !imem_gnt;
    last_addr    = imem_addr;
    if (r && imem_gnt) pend.push_back('{imem_addr, cyc + $urandom_range(lat_max, lat_min)});
    if (!rst_n) begin
      pend.delete();
      model_fpc = ResetPc;
    end else if (pcsrc) begin
      model_fpc = tgt_of(target);
    end else if (r && imem_gnt) begin
      model_fpc = model_fpc + 32'd4;
    end
    if (rst_n) check("outstanding_bound", 32'(pend.size() <= MaxOut), 32'd1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Decode side: valid loads must follow program order from the last redirect.
  task automatic check_d();
    if (pcsrc || flush) begin
      check("kill_valid", 32'(valid_d), 32'd0);
      check("kill_instr", instr_d, Nop);
    end else if (stall) begin
      check("stall_valid", 32'(valid_d), 32'(pv));
      check("stall_instr", instr_d, pi);
      check("stall_pcd", pc_d, pp);
      check("stall_pcp4", pcp4_d, pp4);
    end else if (valid_d) begin
      check("order_pcd", pc_d, exp_pc);
      check("order_instr", instr_d, exp_pc ^ Key);
      check("order_pcp4", pcp4_d, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end else begin
      check("bubble_instr", instr_d, Nop);
      check("bubble_pcd_hold", pc_d, pp);
    end
    if (pcsrc) exp_pc = tgt_of(target);
    pv  = valid_d;
    pi  = instr_d;
    pp  = pc_d;
    pp4 = pcp4_d;
  endtask

  task automatic tick();
    step();
    check_d();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    pcsrc  = 1'b0;
    target = '0;
    last_stalled = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_instr", instr_d, Nop);
    check("rst_pcd", pc_d, 32'd0);
    check("rst_pcp4", pcp4_d, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    pend.delete();
    model_fpc = ResetPc;
    exp_pc    = ResetPc;
    pv  = 1'b0;
    pi  = Nop;
    pp  = '0;
    pp4 = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[21];
    int   found;
    int   seen;

    // Edge n after reset release; gnt always 1, responses one cycle after grant.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h2C, 1'b1};

    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    pcsrc       = 1'b0;
    target      = '0;
    @(negedge clk);

    // Directed table: stream, 6-cycle stall with back-pressure, single flush.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(valid_d), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pcd", i), pc_d, vecs[i].exp_pcd);
        check($sformatf("vec%0d_instr", i), instr_d, vecs[i].exp_pcd ^ Key);
        check($sformatf("vec%0d_pcp4", i), pcp4_d, vecs[i].exp_pcd + 32'd4);
      end else begin
        check($sformatf("vec%0d_nop", i), instr_d, Nop);
      end
    end
    stall = 1'b0;
    flush = 1'b0;

    // Grant withheld for 3 cycles: request and address must hold.
    do_reset();
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nognt_req", 32'(imem_req), 32'd1);
      check("nognt_addr", imem_addr, ResetPc);
    end
    gnt_pct = 100;
    tick();
    check("gnt_advance_addr", imem_addr, ResetPc + 32'd4);

    // Redirect with 0x10/0x14 in flight: both responses must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (pend.size() == 2 && pend[0].addr == 32'h10 && pend[1].addr == 32'h14) found = 1;
    end
    check("redir_setup_found", 32'(found), 32'd1);
    pcsrc  = 1'b1;
    target = 32'h100;
    tick();
    pcsrc = 1'b0;
    seen  = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      tick();
      if (valid_d) begin
        seen = 1;
        check("redir_pcd", pc_d, 32'h100);
        check("redir_instr", instr_d, 32'h100 ^ Key);
      end
    end
    check("redir_valid_seen", 32'(seen), 32'd1);

`ifdef IF_FETCH_MISALIGN_CHECK_EN
    do_reset();
    lat_min = 1; lat_max = 1;
    check("misalign_rst", 32'(misalign), 32'd0);
    pcsrc  = 1'b1;
    target = 32'h102;
    tick();
    pcsrc = 1'b0;
    check("misalign_set", 32'(misalign), 32'd1);
    check("misalign_addr", imem_addr, 32'h100);
    repeat (5) tick();
    check("misalign_sticky", 32'(misalign), 32'd1);
`endif

    // Randomized traffic against the program-order model.
    do_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      stall  = ($urandom_range(99) < 20);
      flush  = ($urandom_range(99) < 8);
      pcsrc  = ($urandom_range(99) < 5);
`ifdef IF_FETCH_MISALIGN_CHECK_EN
      target = 32'($urandom_range(1023));
`else
      target = 32'($urandom_range(255)) << 2;
`endif
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    pcsrc = 1'b0;
    gnt_pct = 100;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      tick();
      if (valid_d) seen = 1;
    end
    check("drain_valid_seen", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
